spawn_arbiter: RTL and testbench



---
 rtl/spawn_pkg.sv | 28 ++
 rtl/spawn_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 36 +++
 rtl/spawn_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spawn_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spawn_pkg.sv
// Shared types and constants for the spawn arbiter and its requesters.
package spawn_pkg;

    // Handshake sequencer states: latch a winner, allocate a slot, acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        ACK   = 2'd2
    } spawn_state_t;

    // Requester indices into req/gnt.
    localparam int REQ_MOUSE = 0;
    localparam int REQ_UART  = 1;
    localparam int REQ_TIMER = 2;

    // Default geometry of the object table.
    localparam int DEF_N_REQ   = 3;
    localparam int DEF_N_SLOTS = 8;
    localparam int DEF_XW      = 11;
    localparam int DEF_YW      = 10;
    localparam int DEF_LIFE_W  = 8;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spawn_arbiter_if.sv
// Bundle between spawn requesters / draw stage (master) and the arbiter (slave).
interface spawn_arbiter_if
    import spawn_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int XW      = DEF_XW,
    parameter int YW      = DEF_YW,
    parameter int LIFE_W  = DEF_LIFE_W
);
    localparam int RW = $clog2(N_SLOTS);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*XW-1:0] req_x;
    logic [N_REQ*YW-1:0] req_y;
    logic [LIFE_W-1:0]   life;
    logic                frame_tick;
    logic                clr_all;
    logic [N_REQ-1:0]    gnt;
    logic                drop;
    logic [N_SLOTS-1:0]  slot_valid;
    logic [RW-1:0]       rd_idx;
    logic [XW-1:0]       rd_x;
    logic [YW-1:0]       rd_y;

    modport master (
        output req, req_x, req_y, life, frame_tick, clr_all, rd_idx,
        input  gnt, drop, slot_valid, rd_x, rd_y
    );

    modport slave (
        input  req, req_x, req_y, life, frame_tick, clr_all, rd_idx,
        output gnt, drop, slot_valid, rd_x, rd_y
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic found;

    // Two passes: indices ptr..N-1 first, then 0..ptr-1 for the wrap.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && IW'(i) >= ptr) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && IW'(i) < ptr) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/spawn_arbiter.sv
// Round-robin spawn arbiter feeding an aging object table with a registered read port.
module spawn_arbiter
    import spawn_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int XW      = DEF_XW,
    parameter int YW      = DEF_YW,
    parameter int LIFE_W  = DEF_LIFE_W
) (
    input logic            clk,
    input logic            rst,
    spawn_arbiter_if.slave bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ALLOC = ALLOC;
    localparam logic [1:0] ST_ACK   = ACK;

    logic [1:0]         state;
    logic [PW-1:0]      rr_ptr;
    logic [N_REQ-1:0]   pick_oh;
    logic [PW-1:0]      pick_idx;
    logic [XW-1:0]      sel_x;
    logic [YW-1:0]      sel_y;

    logic [N_REQ-1:0]   win_oh_q;
    logic [PW-1:0]      win_idx_q;
    logic [XW-1:0]      win_x_q;
    logic [YW-1:0]      win_y_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               drop_q;

    logic [N_SLOTS-1:0] valid_q;
    logic [N_SLOTS-1:0] free_oh;
    logic [N_SLOTS-1:0] alloc_oh;
    logic [N_SLOTS-1:0] expire;
    logic               table_full;
    logic [LIFE_W-1:0]  life_eff;

    logic [XW-1:0]      slot_x    [N_SLOTS];
    logic [YW-1:0]      slot_y    [N_SLOTS];
    logic [LIFE_W-1:0]  slot_life [N_SLOTS];
    logic [XW-1:0]      rd_x_q;
    logic [YW-1:0]      rd_y_q;

    rr_pick #(
        .N  (N_REQ),
        .IW (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // Coordinates of the requester the picker currently favours.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_x = bus.req_x[i*XW +: XW];
                sel_y = bus.req_y[i*YW +: YW];
            end
        end
    end

    // Lowest free slot, allocation strobe, lifetime floor and per-slot expiry.
    always_comb begin
        free_oh    = ~valid_q & (valid_q + N_SLOTS'(1));
        table_full = &valid_q;
        alloc_oh   = (state == ST_ALLOC && !bus.clr_all) ? free_oh : '0;
        life_eff   = (bus.life == '0) ? LIFE_W'(1) : bus.life;
        for (int i = 0; i < N_SLOTS; i++) begin
            expire[i] = bus.frame_tick && valid_q[i] && (slot_life[i] == LIFE_W'(1));
        end
    end

    // Handshake sequencer: latch winner, allocate, acknowledge, advance rr_ptr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
            win_x_q   <= '0;
            win_y_q   <= '0;
            gnt_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            drop_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        win_oh_q  <= pick_oh;
                        win_idx_q <= pick_idx;
                        win_x_q   <= sel_x;
                        win_y_q   <= sel_y;
                        state     <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    gnt_q  <= win_oh_q;
                    drop_q <= table_full && !bus.clr_all;
                    state  <= ST_ACK;
                end
                ST_ACK: begin
                    rr_ptr <= PW'(rr_next(int'(win_idx_q), N_REQ));
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Occupancy: clr_all wins, otherwise expire aged slots and set the allocated one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.clr_all) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q & ~expire) | alloc_oh;
        end
    end

    // Slot payload and lifetime; a freshly written slot skips this frame's decrement.
    always_ff @(posedge clk) begin
        // NOTE: the table storage has no reset; valid_q alone says which entries mean anything.
        for (int i = 0; i < N_SLOTS; i++) begin
            if (alloc_oh[i]) begin
                slot_x[i]    <= win_x_q;
                slot_y[i]    <= win_y_q;
                slot_life[i] <= life_eff;
            end else if (bus.frame_tick && valid_q[i] && slot_life[i] != LIFE_W'(1)) begin
                slot_life[i] <= slot_life[i] - LIFE_W'(1);
            end
        end
    end

    // Registered draw-side read, independent of the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            rd_x_q <= slot_x[bus.rd_idx];
            rd_y_q <= slot_y[bus.rd_idx];
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.drop       = drop_q;
    assign bus.slot_valid = valid_q;
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;

endmodule

// File: tb/tb_spawn_arbiter.sv
// Self-checking bench for spawn_arbiter: vector table, corner sequences, randomized model run.
module tb_spawn_arbiter;
    import spawn_pkg::*;

    localparam int N_REQ   = 3;
    localparam int N_SLOTS = 8;
    localparam int XW      = 11;
    localparam int YW      = 10;
    localparam int LIFE_W  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spawn_arbiter_if #(
        .N_REQ(N_REQ), .N_SLOTS(N_SLOTS), .XW(XW), .YW(YW), .LIFE_W(LIFE_W)
    ) bus ();

    spawn_arbiter #(
        .N_REQ(N_REQ), .N_SLOTS(N_SLOTS), .XW(XW), .YW(YW), .LIFE_W(LIFE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.life       = '0;
        bus.frame_tick = 1'b0;
        bus.clr_all    = 1'b0;
        bus.rd_idx     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int r, input int x, input int y);
        bus.req[r]              = 1'b1;
        bus.req_x[r*XW +: XW]   = XW'(x);
        bus.req_y[r*YW +: YW]   = YW'(y);
    endtask

    // Full single-requester handshake; returns with the arbiter back in IDLE.
    task automatic spawn(input int r, input int x, input int y, input int lf);
        set_req(r, x, y);
        bus.life = LIFE_W'(lf);
        step();
        step();
        bus.req = '0;
        step();
    endtask

    task automatic ftick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    // Directed vector table: one isolated request each, from an empty table.
    typedef struct {
        int         r;
        int         x;
        int         y;
        int         lf;
        logic [2:0] exp_gnt;
        logic       exp_drop;
        logic [7:0] exp_valid;
        int         exp_slot;
    } vec_t;

    vec_t vecs[9];

    // Behavioural model: per-slot remaining frames (0 = free) plus handshake phase.
    int         m_life [N_SLOTS];
    int         m_x    [N_SLOTS];
    int         m_y    [N_SLOTS];
    bit         m_wr   [N_SLOTS];
    int         m_phase;
    int         m_ptr;
    int         m_win;
    int         m_wx;
    int         m_wy;
    logic [2:0] m_gnt;
    logic       m_drop;
    bit         m_rd_ok;
    int         m_rdx;
    int         m_rdy;

    task automatic model_reset();
        for (int k = 0; k < N_SLOTS; k++) begin
            m_life[k] = 0;
            m_wr[k]   = 1'b0;
        end
        m_phase = 0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_drop  = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        int  written;
        bit  found;
        int  cand;
        int  lf;
        written = -1;
        found   = 1'b0;
        m_gnt   = '0;
        m_drop  = 1'b0;
        m_rd_ok = m_wr[bus.rd_idx];
        m_rdx   = m_x[bus.rd_idx];
        m_rdy   = m_y[bus.rd_idx];
        case (m_phase)
            0: begin
                for (int k = 0; k < N_REQ; k++) begin
                    cand = (m_ptr + k) % N_REQ;
                    if (!found && bus.req[cand]) begin
                        found   = 1'b1;
                        m_win   = cand;
                        m_wx    = int'(bus.req_x[cand*XW +: XW]);
                        m_wy    = int'(bus.req_y[cand*YW +: YW]);
                        m_phase = 1;
                    end
                end
            end
            1: begin
                if (!bus.clr_all) begin
                    for (int k = N_SLOTS - 1; k >= 0; k--) begin
                        if (m_life[k] == 0) written = k;
                    end
                    if (written < 0) m_drop = 1'b1;
                end
                m_gnt   = 3'(1 << m_win);
                m_phase = 2;
            end
            default: begin
                m_ptr   = (m_win + 1) % N_REQ;
                m_phase = 0;
            end
        endcase
        if (bus.frame_tick) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (k != written && m_life[k] > 0) m_life[k]--;
            end
        end
        if (written >= 0) begin
            lf = int'(bus.life);
            m_life[written] = (lf < 1) ? 1 : lf;
            m_x[written]    = m_wx;
            m_y[written]    = m_wy;
            m_wr[written]   = 1'b1;
        end
        if (bus.clr_all) begin
            for (int k = 0; k < N_SLOTS; k++) m_life[k] = 0;
        end
    endtask

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < N_SLOTS; k++) v[k] = (m_life[k] > 0);
        return v;
    endfunction

    initial begin
        // Eight spawns fill slots 0..7 in order; the ninth (UART) finds the table full.
        for (int v = 0; v < 8; v++) begin
            vecs[v].r         = v % 3;
            vecs[v].x         = 100 + 37 * v;
            vecs[v].y         = 200 + 11 * v;
            vecs[v].lf        = 5;
            vecs[v].exp_gnt   = 3'(1 << (v % 3));
            vecs[v].exp_drop  = 1'b0;
            vecs[v].exp_valid = 8'((1 << (v + 1)) - 1);
            vecs[v].exp_slot  = v;
        end
        vecs[8] = '{r: REQ_UART, x: 555, y: 333, lf: 5, exp_gnt: 3'b010,
                    exp_drop: 1'b1, exp_valid: 8'hFF, exp_slot: 0};

        // Reset state
        do_reset();
        check("reset gnt", 32'(bus.gnt), 0);
        check("reset drop", 32'(bus.drop), 0);
        check("reset valid", 32'(bus.slot_valid), 0);
        check("reset rd_x", 32'(bus.rd_x), 0);
        check("reset rd_y", 32'(bus.rd_y), 0);

        // Vector table
        for (int v = 0; v < 9; v++) begin
            set_req(vecs[v].r, vecs[v].x, vecs[v].y);
            bus.life = LIFE_W'(vecs[v].lf);
            step();
            check($sformatf("vec%0d gnt early", v), 32'(bus.gnt), 0);
            step();
            check($sformatf("vec%0d gnt", v), 32'(bus.gnt), 32'(vecs[v].exp_gnt));
            check($sformatf("vec%0d drop", v), 32'(bus.drop), 32'(vecs[v].exp_drop));
            check($sformatf("vec%0d valid", v), 32'(bus.slot_valid), 32'(vecs[v].exp_valid));
            bus.req    = '0;
            bus.rd_idx = 3'(vecs[v].exp_slot);
            step();
            check($sformatf("vec%0d gnt one-shot", v), 32'(bus.gnt), 0);
            if (!vecs[v].exp_drop) begin
                check($sformatf("vec%0d rd_x", v), 32'(bus.rd_x), 32'(vecs[v].x));
                check($sformatf("vec%0d rd_y", v), 32'(bus.rd_y), 32'(vecs[v].y));
            end
        end

        // All three requesters held from reset: mouse, UART, timer, mouse, 3 cycles apart
        do_reset();
        set_req(REQ_MOUSE, 10, 11);
        set_req(REQ_UART, 20, 21);
        set_req(REQ_TIMER, 30, 31);
        bus.life = 8'd9;
        for (int c = 0; c <= 10; c++) begin
            logic [2:0] eg;
            step();
            eg = (c == 1) ? 3'b001 : (c == 4) ? 3'b010 : (c == 7) ? 3'b100 :
                 (c == 10) ? 3'b001 : 3'b000;
            check($sformatf("rr cycle%0d gnt", c), 32'(bus.gnt), 32'(eg));
        end
        check("rr valid", 32'(bus.slot_valid), 32'h0F);
        bus.req = '0;

        // Lifetime 3 then lifetime 0
        do_reset();
        spawn(REQ_MOUSE, 1, 2, 3);
        ftick();
        check("life3 tick1", 32'(bus.slot_valid), 32'h01);
        ftick();
        check("life3 tick2", 32'(bus.slot_valid), 32'h01);
        ftick();
        check("life3 tick3", 32'(bus.slot_valid), 32'h00);
        spawn(REQ_TIMER, 3, 4, 0);
        check("life0 spawned", 32'(bus.slot_valid), 32'h01);
        ftick();
        check("life0 tick1", 32'(bus.slot_valid), 32'h00);

        // frame_tick coincident with ALLOC into slot 1
        do_reset();
        spawn(REQ_MOUSE, 5, 6, 3);
        set_req(REQ_UART, 7, 8);
        bus.life = 8'd2;
        step();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        check("coinc valid", 32'(bus.slot_valid), 32'h03);
        bus.req = '0;
        step();
        ftick();
        check("coinc tick+1", 32'(bus.slot_valid), 32'h03);
        ftick();
        check("coinc tick+2", 32'(bus.slot_valid), 32'h00);

        // clr_all during ALLOC
        do_reset();
        spawn(REQ_MOUSE, 9, 9, 4);
        set_req(REQ_MOUSE, 12, 13);
        step();
        bus.clr_all = 1'b1;
        step();
        bus.clr_all = 1'b0;
        check("clr valid", 32'(bus.slot_valid), 0);
        check("clr gnt", 32'(bus.gnt), 32'h1);
        check("clr drop", 32'(bus.drop), 0);
        bus.req = '0;
        step();

        // Reset during ALLOC
        do_reset();
        spawn(REQ_MOUSE, 321, 123, 4);
        bus.rd_idx = 3'd0;
        step();
        check("pre-rst rd_x", 32'(bus.rd_x), 321);
        set_req(REQ_UART, 44, 55);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst gnt", 32'(bus.gnt), 0);
        check("rst drop", 32'(bus.drop), 0);
        check("rst valid", 32'(bus.slot_valid), 0);
        check("rst rd_x", 32'(bus.rd_x), 0);
        check("rst rd_y", 32'(bus.rd_y), 0);
        bus.req = '0;
        step();
        step();
        check("rst no late gnt", 32'(bus.gnt), 0);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!bus.req[r] && $urandom_range(0, 3) == 0)
                    set_req(r, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
            end
            bus.life       = LIFE_W'($urandom_range(0, 12));
            bus.frame_tick = ($urandom_range(0, 3) == 0);
            bus.clr_all    = ($urandom_range(0, 60) == 0);
            bus.rd_idx     = 3'($urandom_range(0, 7));
            model_edge();
            step();
            check("rand gnt", 32'(bus.gnt), 32'(m_gnt));
            check("rand drop", 32'(bus.drop), 32'(m_drop));
            check("rand valid", 32'(bus.slot_valid), 32'(model_valid()));
            if (m_rd_ok) begin
                check("rand rd_x", 32'(bus.rd_x), 32'(m_rdx));
                check("rand rd_y", 32'(bus.rd_y), 32'(m_rdy));
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (m_gnt[r]) bus.req[r] = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
